// File: rtl/cfar_window_detector_pkg.sv
// Shared types and sizing helpers for the CFAR window detector.
package cfar_pkg;

  // Window fill progress within one image line.
  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    RUN   = 2'd3
  } fill_state_e;

  localparam int RING_CELLS = 16;
  localparam int GUARD      = 1;
  localparam int WIN        = 5;

  // 16 ring cells need 4 extra bits over one pixel.
  function automatic int sum_width(input int dw);
    return dw + 4;
  endfunction

  // Ring sum times an 8-bit alpha.
  function automatic int prod_width(input int dw);
    return dw + 12;
  endfunction

endpackage

// File: rtl/cfar_window_detector_if.sv
// Beat-in / result-out bus of the CFAR window detector.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the source holds valid and payload stable until that edge, and
// ready may depend combinationally on the sink's state but never on valid.
interface cfar_window_detector_if #(
  parameter int DATA_WIDTH = 16
);
  logic [7:0]              alpha;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sol;
  logic [10*DATA_WIDTH-1:0] in_pixels;
  logic [11:0]             in_row_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic [11:0]             out_row;
  logic [11:0]             out_col;
  logic [1:0]              out_detect;
  logic [2*DATA_WIDTH-1:0] out_cut;

  modport master (
    output alpha, in_valid, in_sol, in_pixels, in_row_idx, out_ready,
    input  in_ready, out_valid, out_row, out_col, out_detect, out_cut
  );

  modport slave (
    input  alpha, in_valid, in_sol, in_pixels, in_row_idx, out_ready,
    output in_ready, out_valid, out_row, out_col, out_detect, out_cut
  );
endinterface

// File: rtl/cfar_window_detector_ring_sum.sv
// Registered 16-cell ring (noise) sum and CUT value of one 5x5 window.
module cfar_ring_sum
  import cfar_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_en,
  input  logic [WIN*WIN*DATA_WIDTH-1:0]     i_win,
  output logic [sum_width(DATA_WIDTH)-1:0]  o_sum,
  output logic [DATA_WIDTH-1:0]             o_cut
);
  localparam int SW  = sum_width(DATA_WIDTH);
  localparam int MID = WIN / 2;

  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         r_sum;
  logic [DATA_WIDTH-1:0] r_cut;

  // Sum every cell outside the guard block around the centre.
  always_comb begin
    w_sum = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if ((r < MID - GUARD) || (r > MID + GUARD) ||
            (c < MID - GUARD) || (c > MID + GUARD)) begin
          w_sum = w_sum + SW'(i_win[(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  // Capture sum and centre pixel when the pipeline advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cut <= '0;
    end else if (i_en) begin
      r_sum <= w_sum;
      r_cut <= i_win[(MID*WIN+MID)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_sum = r_sum;
  assign o_cut = r_cut;
endmodule

// File: rtl/cfar_window_detector.sv
// Two-CUT-per-beat CFAR detector: window shift, ring sums, threshold compare.
module cfar_window_detector
  import cfar_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_COLS   = 2048,
  parameter int IMG_ROWS   = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  cfar_window_detector_if.slave  bus,
  output fill_state_e            o_dbg_state
);
  localparam int SW = sum_width(DATA_WIDTH);
  localparam int PW = prod_width(DATA_WIDTH);
  localparam logic [11:0] COL_LAST = 12'(IMG_COLS - 2);
  localparam logic [12:0] ROW_LIM  = 13'(IMG_ROWS);
  localparam logic [11:0] ROW_MAX  = 12'(IMG_ROWS - 1);

  logic w_adv, w_acc, w_produce, w_first;
  fill_state_e r_state, w_state_next;

  logic [DATA_WIDTH-1:0] r_win [WIN][6];
  logic [WIN*WIN*DATA_WIDTH-1:0] w_win0, w_win1;

  logic        r_va, r_vb, r_out_valid;
  logic [11:0] r_col_a, r_row_a, r_col_b, r_row_b, w_row_in;
  logic [7:0]  r_alpha_a, r_alpha_b;
  logic [11:0] r_out_row, r_out_col;
  logic [1:0]  r_out_detect;
  logic [2*DATA_WIDTH-1:0] r_out_cut;

  logic [SW-1:0]         w_sum0, w_sum1;
  logic [DATA_WIDTH-1:0] w_cut0, w_cut1;
  logic [PW-1:0]         w_lhs0, w_lhs1, w_rhs0, w_rhs1;

  // A stalled output freezes every stage, so the input waits too.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign w_acc        = bus.in_valid && w_adv;
  assign bus.in_ready = w_adv;
  assign o_dbg_state  = r_state;
  assign w_row_in     = ({1'b0, bus.in_row_idx} < ROW_LIM) ? bus.in_row_idx : ROW_MAX;

  // Fill state register, stepped once per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= FILL0;
    else if (w_acc) r_state <= w_state_next;
  end

  // Next fill state; start-of-line (or the first beat after reset) restarts the line.
  always_comb begin
    w_state_next = r_state;
    if (bus.in_sol || r_state == FILL0) begin
      w_state_next = FILL1;
    end else begin
      case (r_state)
        FILL1:   w_state_next = FILL2;
        FILL2:   w_state_next = RUN;
        RUN:     w_state_next = RUN;
        default: w_state_next = FILL1;
      endcase
    end
  end

  // A beat completes a window once two beats of the line are already buffered.
  always_comb begin
    w_produce = !bus.in_sol && (r_state == FILL2 || r_state == RUN);
    w_first   = (r_state == FILL2);
  end

  // Stage A: shift the 5x6 window by two columns, newest beat on the right.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < 4; c++) r_win[r][c] <= r_win[r][c+2];
        r_win[r][4] <= bus.in_pixels[(r*2)*DATA_WIDTH +: DATA_WIDTH];
        r_win[r][5] <= bus.in_pixels[(r*2+1)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage A tags: result valid, column position, row and alpha of this beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_va      <= 1'b0;
      r_col_a   <= '0;
      r_row_a   <= '0;
      r_alpha_a <= '0;
    end else if (w_adv) begin
      r_va <= w_acc && w_produce;
      if (w_acc && w_produce) begin
        r_col_a   <= w_first ? 12'd0 :
                     (r_col_a >= COL_LAST) ? COL_LAST : r_col_a + 12'd2;
        r_row_a   <= w_row_in;
        r_alpha_a <= bus.alpha;
      end
    end
  end

  // CUT 0 sees columns p0..p4, CUT 1 sees p1..p5.
  always_comb begin
    w_win0 = '0;
    w_win1 = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        w_win0[(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
        w_win1[(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c+1];
      end
    end
  end

  cfar_ring_sum #(.DATA_WIDTH(DATA_WIDTH)) u_ring0 (
    .clk(clk), .rst(rst), .i_en(w_adv), .i_win(w_win0), .o_sum(w_sum0), .o_cut(w_cut0)
  );

  cfar_ring_sum #(.DATA_WIDTH(DATA_WIDTH)) u_ring1 (
    .clk(clk), .rst(rst), .i_en(w_adv), .i_win(w_win1), .o_sum(w_sum1), .o_cut(w_cut1)
  );

  // Stage B tags travel alongside the registered ring sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vb      <= 1'b0;
      r_col_b   <= '0;
      r_row_b   <= '0;
      r_alpha_b <= '0;
    end else if (w_adv) begin
      r_vb      <= r_va;
      r_col_b   <= r_col_a;
      r_row_b   <= r_row_a;
      r_alpha_b <= r_alpha_a;
    end
  end

  // cut*256 against noise*alpha (Q4.4), both at full product width.
  assign w_lhs0 = PW'({w_cut0, 8'h00});
  assign w_lhs1 = PW'({w_cut1, 8'h00});
  assign w_rhs0 = PW'(w_sum0) * PW'(r_alpha_b);
  assign w_rhs1 = PW'(w_sum1) * PW'(r_alpha_b);

  // Stage C: compare into the output registers, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_detect <= '0;
      r_out_cut    <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_vb;
      if (r_vb) begin
        r_out_row    <= r_row_b;
        r_out_col    <= r_col_b;
        r_out_detect <= {w_lhs1 > w_rhs1, w_lhs0 > w_rhs0};
        r_out_cut    <= {w_cut1, w_cut0};
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.out_detect = r_out_detect;
  assign bus.out_cut    = r_out_cut;
endmodule

// File: tb/tb_cfar_window_detector.sv
// Scoreboard bench for cfar_window_detector on an 8x8 image.
module tb_cfar_window_detector;
  import cfar_pkg::*;

  localparam int DW    = 16;
  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int BEATS = (COLS + 4) / 2;
  localparam int EW    = 12 + 12 + 2 + 2*DW;

  logic        clk = 1'b0;
  logic        rst;
  fill_state_e dbg_state;

  cfar_window_detector_if #(.DATA_WIDTH(DW)) bus();

  cfar_window_detector #(.DATA_WIDTH(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int unsigned img [ROWS][COLS];
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
  int gap_max  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain image arithmetic with zero padding.
  function automatic int unsigned pix(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
    return img[r][c];
  endfunction

  function automatic int unsigned noise(input int r, input int c);
    int unsigned s = 0;
    for (int dr = -2; dr <= 2; dr++)
      for (int dc = -2; dc <= 2; dc++)
        if (dr == -2 || dr == 2 || dc == -2 || dc == 2) s += pix(r + dr, c + dc);
    return s;
  endfunction

  function automatic logic det(input int r, input int c, input int unsigned a);
    longint lhs = longint'(pix(r, c)) * 256;
    longint rhs = longint'(noise(r, c)) * longint'(a);
    return lhs > rhs;
  endfunction

  // Ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: pop-and-compare on every transfer, plus hold and ready checks.
  logic          prev_hold = 1'b0;
  logic [EW-1:0] prev_pay;
  always @(negedge clk) begin : monitor
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      act = {bus.out_row, bus.out_col, bus.out_detect, bus.out_cut};
      chk("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_payload", 64'(act), 64'(prev_pay));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(act), 64'd0);
          if (act == 0) begin
            errors++;
            $display("FAIL unexpected_result actual=valid expected=none at %0t", $time);
          end
        end else begin
          exp = exp_q.pop_front();
          chk("result", 64'(act), 64'(exp));
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_pay  = act;
    end
  end

  // Driver: one beat of row r, beat index k (columns 2k-2, 2k-1).
  task automatic send_beat(input int r, input int k, input bit sol, input logic [7:0] a);
    logic [10*DW-1:0] p;
    int  t = 0;
    bit  acc = 0;
    int  c;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 2; cc++)
        p[(rr*2+cc)*DW +: DW] = DW'(pix(r - 2 + rr, 2*k - 2 + cc));
    bus.in_valid   = 1'b1;
    bus.in_sol     = sol;
    bus.in_pixels  = p;
    bus.in_row_idx = 12'(r);
    bus.alpha      = a;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      t++;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept_timeout actual=not_accepted expected=accepted row=%0d beat=%0d", r, k);
    end else if (k >= 2) begin
      c = 2 * (k - 2);
      exp_q.push_back({12'(r), 12'(c), det(r, c + 1, a), det(r, c, a),
                       DW'(pix(r, c + 1)), DW'(pix(r, c))});
    end
  endtask

  task automatic send_row(input int r, input int nbeats, input bit sol, input logic [7:0] a);
    for (int k = 0; k < nbeats; k++) send_beat(r, k, (k == 0) ? sol : 1'b0, a);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); t++; end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (mode)
          0: img[r][c] = 1;
          1: img[r][c] = (r == 4 && c == 4) ? 100 : 1;
          default: img[r][c] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535)
                                                           : $urandom_range(0, 20);
        endcase
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sol = 1'b0; bus.in_pixels = '0;
    bus.in_row_idx = '0; bus.alpha = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_detect", 64'(bus.out_detect), 64'd0);
    chk("rst_out_cut", 64'(bus.out_cut), 64'd0);
    chk("rst_out_row", 64'(bus.out_row), 64'd0);
    chk("rst_out_col", 64'(bus.out_col), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(FILL0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // All-ones image, alpha 1.0: interior no detect, corners detect
    fill_img(0);
    for (int r = 0; r < ROWS; r++) send_row(r, BEATS, 1'b1, 8'h10);
    drain();

    // Single bright pixel
    fill_img(1);
    for (int r = 2; r < 7; r++) send_row(r, BEATS, 1'b1, 8'h10);
    drain();

    // Start-of-line at beat 5: restart with two silent beats then column 0
    send_row(3, 5, 1'b1, 8'h10);
    send_beat(3, 0, 1'b1, 8'h10);
    send_beat(3, 1, 1'b0, 8'h10);
    send_beat(3, 2, 1'b0, 8'h10);
    chk("sol_gap_valid_0", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("sol_gap_valid_1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("sol_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("sol_restart_col", 64'(bus.out_col), 64'd0);
    for (int k = 3; k < BEATS; k++) send_beat(3, k, 1'b0, 8'h10);
    drain();

    // Backpressure: out_ready low for 5 cycles mid-row
    fork
      send_row(4, BEATS, 1'b1, 8'h18);
      begin
        int t = 0;
        while (!bus.out_valid && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #2;
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rdy_mode = 0;
      end
    join
    drain();

    // Reset mid-row, then a row with no start-of-line after reset
    fill_img(2);
    for (int k = 0; k < 4; k++) send_beat(2, k, k == 0, 8'h20);
    #1;
    rst = 1'b1;
    #1;
    chk("midrow_rst_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midrow_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrow_rst_state", 64'(dbg_state), 64'(FILL0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrow_rst_valid_after", 64'(bus.out_valid), 64'd0);
    send_row(2, BEATS, 1'b0, 8'h20);
    send_row(5, BEATS, 1'b1, 8'h14);
    drain();

    // Randomized images, alphas, input gaps and output backpressure
    rdy_mode = 1;
    gap_max  = 2;
    for (int n = 0; n < 6; n++) begin
      fill_img(2);
      for (int r = 0; r < ROWS; r++) send_row(r, BEATS, 1'b1, 8'($urandom_range(0, 255)));
    end
    rdy_mode = 0;
    gap_max  = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
